// File: rtl/vivaz_bus_ctrl.sv
// vivaz_bus_ctrl -- 8080-style parallel write controller for the Vivaz panel.
//
// After reset the controller runs a panel hardware-reset sequence. It then
// accepts command/data words over a valid/ready handshake and writes each
// word with a timed, active-low WR strobe. Words marked as frame start can
// optionally wait for the panel tearing-effect rising edge, with a timeout.
//
// Ports:
//   clk          system clock
//   main_reset   synchronous active-low reset
//   in_valid     word available
//   in_ready     controller accepts a word this cycle (combinational, IDLE only)
//   in_rs        0 = command, 1 = data; driven onto vivaz_RS
//   in_sof       word is the first of a frame (TE alignment candidate)
//   in_data      word to write
//   te_sync_en   enable TE alignment for in_sof words
//   lcd_rst_req  single-cycle request to re-run the panel reset sequence
//   init_done    panel reset sequence complete
//   te_miss      one-cycle pulse when the TE wait timed out
//   vivaz_TE     asynchronous tearing-effect input from the panel
//   vivaz_RS     register select (registered)
//   vivaz_WR     write strobe, active low (registered)
//   vivaz_RESET  panel reset, active low (registered)
//   vivaz_D015   panel data bus (registered)
module vivaz_bus_ctrl #(
  parameter int DATA_W       = 16,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int RST_LOW_CYC  = 1000,
  parameter int RST_WAIT_CYC = 5000,
  parameter int TE_TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              main_reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rs,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  input  logic              te_sync_en,
  input  logic              lcd_rst_req,
  output logic              init_done,
  output logic              te_miss,
  input  logic              vivaz_TE,
  output logic              vivaz_RS,
  output logic              vivaz_WR,
  output logic              vivaz_RESET,
  output logic [DATA_W-1:0] vivaz_D015
);

  // One shared phase counter, sized so the longest phase never wraps.
  localparam int MAX_WR  = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int MAX_RST = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int MAX_A   = (MAX_WR > MAX_RST) ? MAX_WR : MAX_RST;
  localparam int MAX_P   = (MAX_A > TE_TIMEOUT) ? MAX_A : TE_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TE_LAST       = CNT_W'(TE_TIMEOUT - 1);
  // WR_LOW includes one leading setup cycle (WR still high) when entered from
  // IDLE or on a TE timeout, so the low phase ends when the count reaches
  // WR_LOW_CYC. A TE-edge entry skips the setup cycle by starting at 1.
  localparam logic [CNT_W-1:0] WR_LOW_END    = CNT_W'(WR_LOW_CYC);
  localparam logic [CNT_W-1:0] WR_HIGH_LAST  = CNT_W'(WR_HIGH_CYC - 1);

  localparam logic [2:0] ST_RST_ASSERT = 3'd0;
  localparam logic [2:0] ST_RST_WAIT   = 3'd1;
  localparam logic [2:0] ST_IDLE       = 3'd2;
  localparam logic [2:0] ST_TE_WAIT    = 3'd3;
  localparam logic [2:0] ST_WR_LOW     = 3'd4;
  localparam logic [2:0] ST_WR_HIGH    = 3'd5;

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  // [0],[1] synchronise vivaz_TE; [2] is the delayed copy for edge detection.
  logic [2:0]       te_sync_reg;
  logic             te_rise;

  assign te_rise  = te_sync_reg[1] & ~te_sync_reg[2];
  assign in_ready = (state_reg == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!main_reset) begin
      state_reg   <= ST_RST_ASSERT;
      cnt_reg     <= '0;
      te_sync_reg <= '0;
      vivaz_RESET <= 1'b0;
      vivaz_WR    <= 1'b1;
      vivaz_RS    <= 1'b0;
      vivaz_D015  <= '0;
      init_done   <= 1'b0;
      te_miss     <= 1'b0;
    end else begin
      te_sync_reg <= {te_sync_reg[1:0], vivaz_TE};
      te_miss     <= 1'b0;
      case (state_reg)
        ST_RST_ASSERT: begin
          if (cnt_reg == RST_LOW_LAST) begin
            state_reg   <= ST_RST_WAIT;
            cnt_reg     <= '0;
            vivaz_RESET <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        ST_RST_WAIT: begin
          if (cnt_reg == RST_WAIT_LAST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            init_done <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        ST_IDLE: begin
          // A soft reset request wins over a word offered in the same cycle.
          if (lcd_rst_req) begin
            state_reg   <= ST_RST_ASSERT;
            cnt_reg     <= '0;
            init_done   <= 1'b0;
            vivaz_RESET <= 1'b0;
          end else if (in_valid) begin
            vivaz_RS   <= in_rs;
            vivaz_D015 <= in_data;
            cnt_reg    <= '0;
            state_reg  <= (in_sof && te_sync_en) ? ST_TE_WAIT : ST_WR_LOW;
          end
        end
        ST_TE_WAIT: begin
          // An edge in the timeout cycle still counts as an edge.
          if (te_rise) begin
            state_reg <= ST_WR_LOW;
            vivaz_WR  <= 1'b0;
            cnt_reg   <= CNT_ONE;
          end else if (cnt_reg == TE_LAST) begin
            state_reg <= ST_WR_LOW;
            te_miss   <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        ST_WR_LOW: begin
          if (cnt_reg == WR_LOW_END) begin
            state_reg <= ST_WR_HIGH;
            vivaz_WR  <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            vivaz_WR <= 1'b0;
            cnt_reg  <= cnt_reg + CNT_ONE;
          end
        end
        ST_WR_HIGH: begin
          // RS/D are left untouched here to give the panel hold time.
          if (cnt_reg == WR_HIGH_LAST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg   <= ST_RST_ASSERT;
          cnt_reg     <= '0;
          vivaz_RESET <= 1'b0;
          vivaz_WR    <= 1'b1;
          init_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vivaz_bus_ctrl.sv
// tb_vivaz_bus_ctrl -- randomized self-checking bench for vivaz_bus_ctrl.
// A timeline reference model (edge indices of reset release, strobe fall,
// strobe rise, ready return) predicts every output on every cycle.
module tb_vivaz_bus_ctrl;

  localparam int DW   = 16;
  localparam int WRL  = 2;
  localparam int WRH  = 1;
  localparam int RSTL = 4;
  localparam int RSTW = 3;
  localparam int TO   = 20;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          main_reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_rs;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic          te_sync_en;
  logic          lcd_rst_req;
  logic          init_done;
  logic          te_miss;
  logic          vivaz_TE;
  logic          vivaz_RS;
  logic          vivaz_WR;
  logic          vivaz_RESET;
  logic [DW-1:0] vivaz_D015;

  always #5 clk = ~clk;

  vivaz_bus_ctrl #(
    .DATA_W(DW), .WR_LOW_CYC(WRL), .WR_HIGH_CYC(WRH),
    .RST_LOW_CYC(RSTL), .RST_WAIT_CYC(RSTW), .TE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .main_reset(main_reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_sof(in_sof), .in_data(in_data), .te_sync_en(te_sync_en),
    .lcd_rst_req(lcd_rst_req), .init_done(init_done), .te_miss(te_miss),
    .vivaz_TE(vivaz_TE), .vivaz_RS(vivaz_RS), .vivaz_WR(vivaz_WR),
    .vivaz_RESET(vivaz_RESET), .vivaz_D015(vivaz_D015)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: e is the index of the last clock edge.
  int            e = -1;
  int            rst_start = 0;
  int            seq_end = 1 << 30;
  bit            w_active = 1'b0;
  bit            w_wait = 1'b0;
  int            w_acc = 0;
  int            w_fall = 0;
  int            w_end = 0;
  int            miss_edge = -1;
  int            te_rise_edge = -100;
  logic          m_rs = 1'b0;
  logic [DW-1:0] m_d = '0;

  // Bench-side stimulus helpers
  int rst_hold = 0;
  int te_low = 0;
  int te_hi_left = 0;
  bit forced_req = 1'b0;
  bit forced_mid = 1'b0;
  int n_words = 0;
  int n_te_hit = 0;
  int n_te_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, e, got, exp);
  endtask

  // Advance the model by one edge using the inputs the bench drove.
  task automatic model_edge();
    bit ready_pre;
    ready_pre = (e >= seq_end) && !w_active;
    e++;
    if (!main_reset) begin
      rst_start    = e;
      seq_end      = e + RSTL + RSTW;
      w_active     = 1'b0;
      w_wait       = 1'b0;
      m_rs         = 1'b0;
      m_d          = '0;
      miss_edge    = -1;
      te_rise_edge = -100;
    end else begin
      if (ready_pre && lcd_rst_req) begin
        rst_start = e;
        seq_end   = e + RSTL + RSTW;
        $display("edge %0d soft reset (in_valid=%0d ignored)", e, in_valid);
      end else if (ready_pre && in_valid) begin
        m_rs     = in_rs;
        m_d      = in_data;
        w_active = 1'b1;
        w_acc    = e;
        n_words++;
        if (in_sof && te_sync_en) begin
          w_wait = 1'b1;
        end else begin
          w_wait = 1'b0;
          w_fall = e + 1;
          w_end  = w_fall + WRL + WRH;
        end
        $display("edge %0d word rs=%0d data=%04h te_align=%0d", e, in_rs, in_data,
                 in_sof && te_sync_en);
      end else if (w_active && w_wait) begin
        if (te_rise_edge == e) begin
          w_wait = 1'b0;
          w_fall = e;
          n_te_hit++;
        end else if (e == w_acc + TO) begin
          w_wait    = 1'b0;
          miss_edge = e;
          w_fall    = e + 1;
          n_te_miss++;
        end
        if (!w_wait) w_end = w_fall + WRL + WRH;
      end
      if (w_active && !w_wait && e >= w_end) w_active = 1'b0;
    end
  endtask

  initial begin
    logic exp_init, exp_ready, exp_reset, exp_wr, exp_miss;
    main_reset  = 1'b0;
    in_valid    = 1'b0;
    in_rs       = 1'b0;
    in_sof      = 1'b0;
    in_data     = '0;
    te_sync_en  = 1'b0;
    lcd_rst_req = 1'b0;
    vivaz_TE    = 1'b0;
    @(posedge clk);
    model_edge();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      exp_init  = (e >= seq_end);
      exp_ready = exp_init && !w_active;
      exp_reset = (e >= rst_start + RSTL);
      exp_wr    = !(w_active && !w_wait && e >= w_fall && e < w_fall + WRL);
      exp_miss  = (e == miss_edge);
      check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
      check_eq("init_done", 32'(init_done), 32'(exp_init));
      check_eq("vivaz_RESET", 32'(vivaz_RESET), 32'(exp_reset));
      check_eq("vivaz_WR", 32'(vivaz_WR), 32'(exp_wr));
      check_eq("te_miss", 32'(te_miss), 32'(exp_miss));
      check_eq("vivaz_RS", 32'(vivaz_RS), 32'(m_rs));
      check_eq("vivaz_D015", 32'(vivaz_D015), 32'(m_d));

      // main reset: 3 initial edges, one forced abort mid-strobe, rare random pulses
      if (e < 2) begin
        main_reset = 1'b0;
      end else if (rst_hold > 0) begin
        main_reset = 1'b0;
        rst_hold--;
      end else if (!forced_mid && e > 1500 && !exp_wr) begin
        main_reset = 1'b0;
        forced_mid = 1'b1;
        $display("edge %0d main reset during strobe low", e);
      end else if ($urandom_range(0, 499) == 0) begin
        main_reset = 1'b0;
        rst_hold   = $urandom_range(0, 2);
      end else begin
        main_reset = 1'b1;
      end

      in_valid   = ($urandom_range(0, 3) != 0);
      in_rs      = 1'($urandom);
      in_data    = DW'($urandom);
      in_sof     = ($urandom_range(0, 2) == 0);
      te_sync_en = 1'($urandom);
      if (!forced_req && e > 800 && exp_ready) begin
        lcd_rst_req = 1'b1;
        in_valid    = 1'b1;
        forced_req  = 1'b1;
      end else begin
        lcd_rst_req = ($urandom_range(0, 79) == 0);
      end

      // Tearing-effect pulses: kept low around reset, at least 3 low cycles apart
      if (!main_reset) begin
        vivaz_TE = 1'b0;
        te_low   = 0;
      end else if (vivaz_TE) begin
        if (te_hi_left == 0) begin
          vivaz_TE = 1'b0;
          te_low   = 0;
        end else begin
          te_hi_left--;
        end
      end else begin
        te_low++;
        if (te_low >= 3 && $urandom_range(0, 9) == 0) begin
          vivaz_TE     = 1'b1;
          te_hi_left   = $urandom_range(0, 3);
          te_rise_edge = e + 3;
        end
      end

      @(posedge clk);
      model_edge();
    end
    $display("words=%0d te_aligned=%0d te_timeouts=%0d", n_words, n_te_hit, n_te_miss);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
